// File: rtl/hpdcache_sync_rd_serializer.sv
// Pops one multi-word message from a sync buffer, latches it locally and
// replays it one word per beat on a narrow valid/ready output.
module hpdcache_sync_rd_serializer #(
  parameter int unsigned NWORDS = 4,
  parameter type         word_t = logic [63:0],
  parameter int unsigned LENW   = $clog2(NWORDS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rok_i,
  output logic                     r_o,
  input  word_t [NWORDS-1:0]       rdata_i,
  input  logic  [LENW-1:0]         rlen_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output word_t                    data_o,
  output logic  [LENW-1:0]         idx_o,
  output logic                     last_o,
  output logic                     busy_o
);

  localparam int unsigned WORDW = $bits(word_t);
  localparam logic [LENW-1:0] LAST_IDX = LENW'(NWORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e             state_r, state_s;
  word_t [NWORDS-1:0] buf_r, buf_s;
  logic  [LENW-1:0]   len_r, len_s;
  logic  [LENW-1:0]   cnt_r, cnt_s;
  logic  [LENW-1:0]   cnt_inc_s;
  logic  [LENW-1:0]   len_in_s;
  logic               valid_r, valid_s;
  word_t              data_r, data_s;
  logic  [LENW-1:0]   idx_r, idx_s;
  logic               last_r, last_s;
  logic               beat_s;
  logic               load_s;

  // Clamp an out-of-range length (only reachable for non-power-of-2 NWORDS)
  always_comb begin
    len_in_s = rlen_i;
    if (rlen_i > LAST_IDX) begin
      len_in_s = LAST_IDX;
    end else begin
      len_in_s = rlen_i;
    end
  end

  // Pop decision: only when idle or on the accepted last beat, never during reset
  always_comb begin
    beat_s    = valid_r & ready_i;
    cnt_inc_s = cnt_r + LENW'(1);
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: load_s = rok_i & rst_ni;
      ST_SEND: load_s = rok_i & rst_ni & beat_s & last_r;
      default: load_s = 1'b0;
    endcase
  end

  // Next-state and next-output computation; outputs are precomputed so they leave flops
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    len_s   = len_r;
    cnt_s   = cnt_r;
    valid_s = valid_r;
    data_s  = data_r;
    idx_s   = idx_r;
    last_s  = last_r;

    if (load_s) begin
      state_s = ST_SEND;
      buf_s   = rdata_i;
      len_s   = len_in_s;
      cnt_s   = {LENW{1'b0}};
      valid_s = 1'b1;
      data_s  = rdata_i[0];
      idx_s   = {LENW{1'b0}};
      last_s  = (len_in_s == {LENW{1'b0}});
    end else begin
      case (state_r)
        ST_SEND: begin
          if (beat_s && last_r) begin
            state_s = ST_IDLE;
            cnt_s   = {LENW{1'b0}};
            valid_s = 1'b0;
            data_s  = buf_r[0];
            idx_s   = {LENW{1'b0}};
            last_s  = 1'b0;
          end else if (beat_s) begin
            cnt_s   = cnt_inc_s;
            data_s  = buf_r[cnt_inc_s];
            idx_s   = cnt_inc_s;
            last_s  = (cnt_inc_s == len_r);
          end else begin
            state_s = state_r;
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = {LENW{1'b0}};
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      endcase
    end
  end

  // State, buffer and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      buf_r   <= {(NWORDS * WORDW){1'b0}};
      len_r   <= {LENW{1'b0}};
      cnt_r   <= {LENW{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {WORDW{1'b0}};
      idx_r   <= {LENW{1'b0}};
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;
      len_r   <= len_s;
      cnt_r   <= cnt_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      idx_r   <= idx_s;
      last_r  <= last_s;
    end
  end

  assign r_o     = load_s;
  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign idx_o   = idx_r;
  assign last_o  = last_r;
  assign busy_o  = (state_r == ST_SEND);

endmodule

// File: tb/tb_hpdcache_sync_rd_serializer.sv
// Directed table-driven bench for the sync-buffer read serializer, with
// hand-written sequences for reset mid-message and length clamping.
module tb_hpdcache_sync_rd_serializer;

  logic clk;
  logic rst_n;

  logic             rok, r, ready, valid, last, busy;
  logic [3:0][63:0] rdata;
  logic [1:0]       rlen, idx;
  logic [63:0]      data;

  logic             rok3, r3, ready3, valid3, last3, busy3;
  logic [2:0][63:0] rdata3;
  logic [1:0]       rlen3, idx3;
  logic [63:0]      data3;

  int passed = 0;
  int total  = 0;

  hpdcache_sync_rd_serializer #(.NWORDS(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .rok_i(rok), .r_o(r), .rdata_i(rdata),
    .rlen_i(rlen), .valid_o(valid), .ready_i(ready), .data_o(data),
    .idx_o(idx), .last_o(last), .busy_o(busy)
  );

  hpdcache_sync_rd_serializer #(.NWORDS(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .rok_i(rok3), .r_o(r3), .rdata_i(rdata3),
    .rlen_i(rlen3), .valid_o(valid3), .ready_i(ready3), .data_o(data3),
    .idx_o(idx3), .last_o(last3), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rok;
    logic [1:0]       rlen;
    logic [3:0][63:0] rdata;
    logic             rdy;
    logic             e_r;
    logic             e_v;
    logic [63:0]      e_d;
    logic [1:0]       e_idx;
    logic             e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0][63:0] msg(input logic [63:0] base);
    logic [3:0][63:0] m;
    for (int k = 0; k < 4; k++) m[k] = base + 64'(k);
    return m;
  endfunction

  function automatic vec_t mk(input logic rk, input logic [1:0] rl, input logic [3:0][63:0] rd,
                              input logic rdy, input logic er, input logic ev,
                              input logic [63:0] ed, input logic [1:0] ei, input logic el);
    vec_t v;
    v.rok = rk; v.rlen = rl; v.rdata = rd; v.rdy = rdy;
    v.e_r = er; v.e_v = ev; v.e_d = ed; v.e_idx = ei; v.e_last = el;
    return v;
  endfunction

  initial begin
    logic [3:0][63:0] z;
    z = msg(64'h0);

    // T1 single word
    tbl.push_back(mk(1'b1, 2'd0, msg(64'hA5), 1'b1, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z,           1'b1, 1'b0, 1'b1, 64'hA5, 2'd0, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, z,           1'b1, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0));
    // T2 four words with alternating backpressure
    tbl.push_back(mk(1'b1, 2'd3, msg(64'h10), 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h10, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b0, 1'b0, 1'b1, 64'h11, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h11, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b0, 1'b0, 1'b1, 64'h12, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h12, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b0, 1'b0, 1'b1, 64'h13, 2'd3, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h13, 2'd3, 1'b1));
    // ready while idle is ignored
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b0, 1'b0, 1'b0, 64'h0, 2'd0, 1'b0));
    // T3 back-to-back rlen=1 then rlen=2
    tbl.push_back(mk(1'b1, 2'd1, msg(64'h20), 1'b1, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, msg(64'h30), 1'b1, 1'b0, 1'b1, 64'h20, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, msg(64'h30), 1'b1, 1'b1, 1'b1, 64'h21, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h30, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h31, 2'd1, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h32, 2'd2, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0));
    // T4 upstream holds a message while SEND is ongoing
    tbl.push_back(mk(1'b1, 2'd1, msg(64'h40), 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, msg(64'h50), 1'b0, 1'b0, 1'b1, 64'h40, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, msg(64'h50), 1'b1, 1'b0, 1'b1, 64'h40, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, msg(64'h50), 1'b0, 1'b0, 1'b1, 64'h41, 2'd1, 1'b1));
    tbl.push_back(mk(1'b1, 2'd0, msg(64'h50), 1'b1, 1'b1, 1'b1, 64'h41, 2'd1, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b1, 1'b0, 1'b1, 64'h50, 2'd0, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, z, 1'b0, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0));

    // Reset state, with rok high to show r_o is held low
    rst_n = 1'b0;
    rok = 1'b1; rlen = 2'd0; rdata = z; ready = 1'b0;
    rok3 = 1'b1; rlen3 = 2'd0; rdata3 = '0; ready3 = 1'b0;
    #12;
    check("reset r_o", 64'(r), 64'h0);
    check("reset valid_o", 64'(valid), 64'h0);
    check("reset last_o", 64'(last), 64'h0);
    check("reset idx_o", 64'(idx), 64'h0);
    check("reset busy_o", 64'(busy), 64'h0);
    check("reset data_o", data, 64'h0);
    check("reset r_o n3", 64'(r3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; rok = 1'b0; rok3 = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rok = tbl[i].rok; rlen = tbl[i].rlen; rdata = tbl[i].rdata; ready = tbl[i].rdy;
      #1;
      check($sformatf("step%0d r_o", i), 64'(r), 64'(tbl[i].e_r));
      check($sformatf("step%0d valid_o", i), 64'(valid), 64'(tbl[i].e_v));
      check($sformatf("step%0d busy_o", i), 64'(busy), 64'(tbl[i].e_v));
      check($sformatf("step%0d last_o", i), 64'(last), 64'(tbl[i].e_last));
      if (tbl[i].e_v) begin
        check($sformatf("step%0d idx_o", i), 64'(idx), 64'(tbl[i].e_idx));
        check($sformatf("step%0d data_o", i), data, tbl[i].e_d);
      end
    end

    // T5 reset asserted at beat idx 1 of an rlen=3 message
    @(negedge clk);
    rok = 1'b1; rlen = 2'd3; rdata = msg(64'h60); ready = 1'b1;
    #1 check("t5 pop", 64'(r), 64'h1);
    @(negedge clk);
    rok = 1'b0;
    #1 check("t5 beat0 data", data, 64'h60);
    @(negedge clk);
    #1 check("t5 beat1 idx", 64'(idx), 64'h1);
    check("t5 beat1 valid", 64'(valid), 64'h1);
    #1;
    rst_n = 1'b0; rok = 1'b1;
    #1;
    check("t5 rst valid_o", 64'(valid), 64'h0);
    check("t5 rst r_o", 64'(r), 64'h0);
    check("t5 rst busy_o", 64'(busy), 64'h0);
    @(posedge clk);
    #1 check("t5 rst r_o held", 64'(r), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; rok = 1'b1; rlen = 2'd3; rdata = msg(64'h70); ready = 1'b1;
    #1 check("t5 fresh pop", 64'(r), 64'h1);
    @(negedge clk);
    rok = 1'b0;
    #1;
    check("t5 fresh valid", 64'(valid), 64'h1);
    check("t5 fresh idx", 64'(idx), 64'h0);
    check("t5 fresh data", data, 64'h70);

    // T6 NWORDS=3 with rlen=3 clamps to three beats
    @(negedge clk);
    rok3 = 1'b1; rlen3 = 2'd3; rdata3 = {64'h82, 64'h81, 64'h80}; ready3 = 1'b1;
    #1 check("t6 pop", 64'(r3), 64'h1);
    @(negedge clk);
    rok3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t6 beat%0d valid", k), 64'(valid3), 64'h1);
      check($sformatf("t6 beat%0d idx", k), 64'(idx3), 64'(k));
      check($sformatf("t6 beat%0d data", k), data3, 64'h80 + 64'(k));
      check($sformatf("t6 beat%0d last", k), 64'(last3), (k == 2) ? 64'h1 : 64'h0);
      @(negedge clk);
    end
    #1 check("t6 done valid", 64'(valid3), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
